// File: rtl/pdm_multichannel_modulator.sv
// Multi-channel first-order sigma-delta PDM modulator with shadowed sample loading,
// shared tick divider and shift attenuation. Optional LFSR dither: define PDM_DITHER_EN.
module pdm_multichannel_modulator #(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 8,
   parameter int SHIFT_W  = 4,
   parameter int DIV_W    = 8,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [DIV_W-1:0]    div,
   input  logic [SHIFT_W-1:0]  shift_by,
   input  logic                s_valid,
   input  logic [CH_W-1:0]     s_chan,
   input  logic [DATA_W-1:0]   s_data,
   output logic                s_ready,
   output logic                tick,
   output logic [CHANNELS-1:0] pdm_out
);

   logic [DIV_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_acc    [CHANNELS];
   logic [DATA_W-1:0]   r_active [CHANNELS];
   logic [DATA_W-1:0]   r_shadow [CHANNELS];
   logic [CHANNELS-1:0] r_pending;

   logic                w_commit;
   logic                w_mute;
   logic                w_carry;
   logic [CHANNELS-1:0] w_sel;
   logic [CHANNELS-1:0] w_wr;
   logic [DATA_W-1:0]   w_value [CHANNELS];
   logic [DATA_W-1:0]   w_eff   [CHANNELS];
   logic [DATA_W:0]     w_sum   [CHANNELS];

   // Using >= rather than == lets a shrinking div take effect immediately.
   assign w_commit = ena && (r_cnt >= div);
   assign w_mute   = (int'(shift_by) >= DATA_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         tick  <= 1'b0;
      end else if (ena) begin
         if (r_cnt >= div) begin
            r_cnt <= '0;
            tick  <= 1'b1;
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
            tick  <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

`ifdef PDM_DITHER_EN
   logic [15:0] r_lfsr;

   // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, stepped once per modulation step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= 16'hACE1;
      end else if (w_commit) begin
         r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      end
   end

   assign w_carry = r_lfsr[0];
`else
   assign w_carry = 1'b0;
`endif

   // Out-of-range channel numbers match no channel, so they are always ready and dropped.
   always_comb begin
      w_sel = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_sel[c] = (s_chan == CH_W'(c));
      end
   end

   assign s_ready = ~|(w_sel & r_pending);
   assign w_wr    = {CHANNELS{s_valid}} & w_sel & ~r_pending;

   // A write landing in the commit cycle is used directly instead of via the shadow.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         w_value[c] = r_active[c];
         if (w_wr[c]) begin
            w_value[c] = s_data;
         end else if (r_pending[c]) begin
            w_value[c] = r_shadow[c];
         end
         w_eff[c] = w_mute ? '0 : (w_value[c] >> shift_by);
         w_sum[c] = {1'b0, r_acc[c]} + {1'b0, w_eff[c]} + {{DATA_W{1'b0}}, w_carry};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_acc[c]    <= '0;
            r_active[c] <= '0;
            r_shadow[c] <= '0;
         end
         r_pending <= '0;
         pdm_out   <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (w_wr[c]) begin
               r_shadow[c] <= s_data;
            end
            if (w_commit) begin
               r_active[c]  <= w_value[c];
               r_pending[c] <= 1'b0;
               r_acc[c]     <= w_sum[c][DATA_W-1:0];
               pdm_out[c]   <= w_sum[c][DATA_W];
            end else if (w_wr[c]) begin
               r_pending[c] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pdm_multichannel_modulator.sv
// Scoreboard bench for pdm_multichannel_modulator: stimulus queues hand-computed
// pdm_out vectors, a monitor compares them on every tick and tracks tick timing.
module tb_pdm_multichannel_modulator;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic       ena      = 1'b0;
   logic [7:0] div      = 8'd0;
   logic [3:0] shift_by = 4'd0;
   logic       s_valid  = 1'b0;
   logic [1:0] s_chan   = 2'd0;
   logic [7:0] s_data   = 8'd0;
   logic       s_ready;
   logic       tick;
   logic [3:0] pdm_out;

   int         checkCount    = 0;
   int         errorCount    = 0;
   logic [3:0] sbQueue[$];
   int         tickCount     = 0;
   int         countLimit    = 0;
   int         onesCount[4];
   int         cycleCount;
   int         prevTickCycle = -1;
   int         expectFirst   = 0;
   int         expectGap     = 0;
   logic [3:0] prevPdm       = 4'd0;

   pdm_multichannel_modulator #(
      .CHANNELS(4),
      .DATA_W  (8),
      .SHIFT_W (4),
      .DIV_W   (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .div     (div),
      .shift_by(shift_by),
      .s_valid (s_valid),
      .s_chan  (s_chan),
      .s_data  (s_data),
      .s_ready (s_ready),
      .tick    (tick),
      .pdm_out (pdm_out)
   );

   always #5 clk = ~clk;

   // Cycle numbering restarts at reset so tick timing can be checked in absolute terms.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cycleCount <= 0;
      else        cycleCount <= cycleCount + 1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: each tick pops one expected vector; between ticks pdm_out must not move.
   always @(negedge clk) begin
      logic [3:0] expVec;
      if (!rst_n) begin
         tickCount     = 0;
         onesCount     = '{default: 0};
         prevTickCycle = -1;
         prevPdm       = 4'd0;
      end else begin
         if (tick) begin
            if (sbQueue.size() > 0) begin
               expVec = sbQueue.pop_front();
               checkOutput("pdmVector", int'(pdm_out), int'(expVec));
            end
            if (tickCount < countLimit) begin
               tickCount++;
               for (int c = 0; c < 4; c++) onesCount[c] += int'(pdm_out[c]);
            end
            if (prevTickCycle < 0 && expectFirst > 0)
               checkOutput("firstTickCycle", cycleCount, expectFirst);
            if (prevTickCycle >= 0 && expectGap > 0)
               checkOutput("tickGap", cycleCount - prevTickCycle, expectGap);
            prevTickCycle = cycleCount;
         end else begin
            checkOutput("pdmHold", int'(pdm_out), int'(prevPdm));
         end
         prevPdm = pdm_out;
      end
   end

   task automatic resetDut(input logic enaV, input logic [7:0] divV, input logic [3:0] shiftV);
      @(negedge clk);
      rst_n    = 1'b0;
      ena      = enaV;
      div      = divV;
      shift_by = shiftV;
      s_valid  = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic releaseReset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input int chan, input logic [7:0] data, output int acceptCycle);
      int n;
      s_valid = 1'b1;
      s_chan  = 2'(chan);
      s_data  = data;
      #1;
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!s_ready) checkOutput("readyTimeout", 0, 1);
      acceptCycle = cycleCount;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic waitTicks(input int budget);
      int n;
      n = 0;
      while (tickCount < countLimit && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (tickCount < countLimit) checkOutput("tickTimeout", tickCount, countLimit);
      @(negedge clk);
      checkOutput("scoreboardDrained", sbQueue.size(), 0);
   endtask

`ifdef PDM_DITHER_EN
   task automatic ditherTest();
      logic [15:0] lf;
      logic [7:0]  acc;
      logic [8:0]  sum;
      int          modelOnes;
      lf        = 16'hACE1;
      acc       = 8'd0;
      modelOnes = 0;
      resetDut(1'b0, 8'd0, 4'd0);
      for (int t = 0; t < 1024; t++) begin
         sum = {1'b0, acc} + {8'd0, lf[0]};
         acc = sum[7:0];
         modelOnes += int'(sum[8]);
         sbQueue.push_back({4{sum[8]}});
         lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
      end
      releaseReset();
      countLimit = 1024;
      ena = 1'b1;
      waitTicks(3000);
      ena = 1'b0;
      checkOutput("ditherOnesCh0", onesCount[0], modelOnes);
      checkOutput("ditherNonzero", int'(onesCount[0] > 0), 1);
   endtask
`endif

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acceptCycle;
      int c0;

      resetDut(1'b0, 8'd0, 4'd0);
      checkOutput("resetPdm", int'(pdm_out), 0);
      checkOutput("resetTick", int'(tick), 0);
      for (int c = 0; c < 4; c++) begin
         s_chan = 2'(c);
         #1;
         checkOutput("resetReady", int'(s_ready), 1);
      end

`ifdef PDM_DITHER_EN
      ditherTest();
`else
      // ch0=128 alternates, ch1=255 is one short of full scale.
      resetDut(1'b0, 8'd0, 4'd0);
      releaseReset();
      applyStimulus(0, 8'd128, acceptCycle);
      applyStimulus(1, 8'd255, acceptCycle);
      sbQueue.push_back(4'b0000);
      sbQueue.push_back(4'b0011);
      sbQueue.push_back(4'b0010);
      sbQueue.push_back(4'b0011);
      countLimit = 256;
      ena = 1'b1;
      waitTicks(2000);
      checkOutput("onesCh0Half", onesCount[0], 128);
      checkOutput("onesCh1Full", onesCount[1], 255);
      checkOutput("onesCh2Idle", onesCount[2], 0);
      checkOutput("onesCh3Idle", onesCount[3], 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncClearPdm", int'(pdm_out), 0);
      checkOutput("asyncClearTick", int'(tick), 0);

      // Shift by 2 on all channels.
      resetDut(1'b0, 8'd0, 4'd2);
      releaseReset();
      applyStimulus(0, 8'd128, acceptCycle);
      applyStimulus(1, 8'd255, acceptCycle);
      applyStimulus(2, 8'd64, acceptCycle);
      applyStimulus(3, 8'd200, acceptCycle);
      for (int i = 0; i < 4; i++) sbQueue.push_back(4'b0000);
      sbQueue.push_back(4'b0010);
      sbQueue.push_back(4'b1000);
      countLimit = 256;
      ena = 1'b1;
      waitTicks(2000);
      checkOutput("onesShift2Ch0", onesCount[0], 32);
      checkOutput("onesShift2Ch1", onesCount[1], 63);
      checkOutput("onesShift2Ch2", onesCount[2], 16);
      checkOutput("onesShift2Ch3", onesCount[3], 50);

      // Shift of DATA_W mutes every channel.
      resetDut(1'b0, 8'd0, 4'd8);
      releaseReset();
      applyStimulus(0, 8'd128, acceptCycle);
      applyStimulus(1, 8'd255, acceptCycle);
      sbQueue.push_back(4'b0000);
      sbQueue.push_back(4'b0000);
      countLimit = 64;
      ena = 1'b1;
      waitTicks(1000);
      checkOutput("onesShift8Ch0", onesCount[0], 0);
      checkOutput("onesShift8Ch1", onesCount[1], 0);

      // div=3 with a bypass write to ch1 exactly in the first commit cycle.
      resetDut(1'b1, 8'd3, 4'd0);
      expectFirst = 4;
      expectGap   = 4;
      sbQueue.push_back(4'b0000);
      sbQueue.push_back(4'b0011);
      sbQueue.push_back(4'b0010);
      sbQueue.push_back(4'b0011);
      sbQueue.push_back(4'b0000);
      countLimit = 5;
      releaseReset();
      applyStimulus(0, 8'd128, acceptCycle);
      @(negedge clk);
      @(negedge clk);
      applyStimulus(1, 8'd200, acceptCycle);
      checkOutput("bypassCycle", acceptCycle, 3);
      s_chan = 2'd1;
      #1;
      checkOutput("bypassNoPending", int'(s_ready), 1);
      waitTicks(200);
      expectFirst = 0;
      expectGap   = 0;
      div = 8'd200;
      repeat (5) @(negedge clk);
      div = 8'd2;
      c0  = cycleCount;
      @(negedge clk);
      checkOutput("divShrinkTick", int'(tick), 1);
      checkOutput("divShrinkLatency", cycleCount - c0, 1);
      @(negedge clk);
      expectGap = 3;
      repeat (8) @(negedge clk);
      expectGap = 0;

      // Second write to ch3 stalls until the commit at cycle 8.
      resetDut(1'b1, 8'd7, 4'd0);
      expectFirst = 8;
      expectGap   = 8;
      for (int i = 0; i < 4; i++) sbQueue.push_back(4'b0000);
      sbQueue.push_back(4'b1000);
      countLimit = 5;
      releaseReset();
      @(negedge clk);
      applyStimulus(3, 8'd100, acceptCycle);
      s_chan = 2'd3;
      #1;
      checkOutput("stallReady", int'(s_ready), 0);
      applyStimulus(3, 8'd50, acceptCycle);
      checkOutput("stallReleaseCycle", acceptCycle, 8);
      waitTicks(400);
      expectFirst = 0;
      expectGap   = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
